// File: rtl/mpu6050_read_sched.sv
// Reads MPU6050 registers BASE_ADDR..BASE_ADDR+13 through a shared I2C byte-read master on each accepted tick,
// then publishes seven 16-bit words together. Also counts dropped ticks and aborted frames.
module mpu6050_read_sched #(
  parameter logic [7:0] BASE_ADDR   = 8'h3B,
  parameter int         TIMEOUT_CYC = 50000,
  parameter int         CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init_done,
  input  logic             tick,
  output logic             rd_req,
  output logic [7:0]       rd_addr,
  input  logic             rd_ack,
  input  logic             rd_done,
  input  logic [7:0]       rd_data,
  input  logic             rd_err,
  output logic             busy,
  output logic [15:0]      ax,
  output logic [15:0]      ay,
  output logic [15:0]      az,
  output logic [15:0]      temp,
  output logic [15:0]      gx,
  output logic [15:0]      gy,
  output logic [15:0]      gz,
  output logic             sample_valid,
  output logic [CNT_W-1:0] overrun_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int            TW     = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t        state, state_nxt;
  logic [3:0]    idx, idx_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [7:0]    shadow [14];
  logic          shadow_we, publish, abort, overrun;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    timer_nxt = timer;
    shadow_we = 1'b0;
    publish   = 1'b0;
    abort     = 1'b0;
    overrun   = tick && (state != IDLE);
    case (state)
      IDLE: begin
        if (tick && init_done) begin
          state_nxt = REQ;
          idx_nxt   = 4'd0;
          timer_nxt = '0;
        end
      end
      REQ: begin
        timer_nxt = timer + 1'b1;
        if (!init_done)           state_nxt = IDLE;
        else if (timer == T_LAST) abort     = 1'b1;
        else if (rd_ack)          state_nxt = WAIT;
      end
      WAIT: begin
        timer_nxt = timer + 1'b1;
        if (!init_done) begin
          state_nxt = IDLE;
        end else if (rd_done && !rd_err) begin
          // A good byte on the expiry cycle still wins over the timeout.
          shadow_we = 1'b1;
          if (idx == 4'd13) begin
            publish   = 1'b1;
            state_nxt = IDLE;
          end else begin
            idx_nxt   = idx + 4'd1;
            timer_nxt = '0;
            state_nxt = REQ;
          end
        end else if (rd_done || timer == T_LAST) begin
          abort = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= 4'd0;
      timer <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      timer <= timer_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_req       <= 1'b0;
      rd_addr      <= 8'h00;
      busy         <= 1'b0;
      sample_valid <= 1'b0;
      overrun_cnt  <= '0;
      err_cnt      <= '0;
      ax           <= 16'h0;
      ay           <= 16'h0;
      az           <= 16'h0;
      temp         <= 16'h0;
      gx           <= 16'h0;
      gy           <= 16'h0;
      gz           <= 16'h0;
      for (int i = 0; i < 14; i++) shadow[i] <= 8'h00;
    end else begin
      rd_req       <= (state_nxt == REQ);
      rd_addr      <= BASE_ADDR + {4'd0, idx_nxt};
      busy         <= (state_nxt != IDLE);
      sample_valid <= publish;
      if (overrun && overrun_cnt != '1) overrun_cnt <= overrun_cnt + 1'b1;
      if (abort && err_cnt != '1)       err_cnt     <= err_cnt + 1'b1;
      if (shadow_we) shadow[idx] <= rd_data;
      // The final byte is taken straight from rd_data so all seven words update together.
      if (publish) begin
        ax   <= {shadow[0],  shadow[1]};
        ay   <= {shadow[2],  shadow[3]};
        az   <= {shadow[4],  shadow[5]};
        temp <= {shadow[6],  shadow[7]};
        gx   <= {shadow[8],  shadow[9]};
        gy   <= {shadow[10], shadow[11]};
        gz   <= {shadow[12], rd_data};
      end
    end
  end

endmodule

// File: doc/mpu6050_read_sched.md
Name: mpu6050_read_sched

Overview:
- Sequencer between the 5 ms read tick and the shared I2C byte-read master.
- On each accepted tick it burst-reads the 14 MPU6050 data registers (0x3B..0x48: accel X/Y/Z, temp, gyro X/Y/Z) one byte at a time.
- Assembles the bytes into seven 16-bit words and publishes them atomically with a one-cycle valid strobe.
- Detects and counts dropped ticks (overrun), bus errors and byte timeouts.

Parameters:
- BASE_ADDR, 8'h3B, register address of the first byte read (ACCEL_XOUT_H).
- TIMEOUT_CYC, 50000, per-byte limit in clk cycles from REQ entry to rd_done (1 ms at 50 MHz); must be >= 2.
- CNT_W, 8, width of the saturating overrun/error counters.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous reset, active-high.
- init_done, input, 1, sensor configuration complete; frames start only while it is high.
- tick, input, 1, one-cycle read request pulse (5 ms period).
- rd_req, output, 1, byte-read request to the I2C master.
- rd_addr, output, 8, register address for the current request.
- rd_ack, input, 1, master accepted the request.
- rd_done, input, 1, one-cycle pulse: byte read finished.
- rd_data, input, 8, read byte; valid with rd_done.
- rd_err, input, 1, NACK/bus error; valid with rd_done.
- busy, output, 1, frame in progress (state != IDLE).
- ax, ay, az, temp, gx, gy, gz, output, 16 each, latest complete sample, two's complement as read.
- sample_valid, output, 1, one-cycle strobe: the seven words were just updated.
- overrun_cnt, output, CNT_W, saturating count of dropped ticks.
- err_cnt, output, CNT_W, saturating count of aborted frames (rd_err or timeout).

Behaviour:
- Reset: all outputs 0; state IDLE; byte_idx 0; timer 0; shadow buffer 0. All outputs are registered.
- States and transitions:
  - IDLE: if tick && init_done, go to REQ next cycle with byte_idx=0 and timer=0. A tick while init_done=0 is ignored and not counted.
  - REQ: rd_req=1, rd_addr=BASE_ADDR+byte_idx. Both hold stable until rd_ack is sampled high; then go to WAIT and rd_req=0 from the next cycle.
  - WAIT: on rd_done with rd_err=0, write rd_data to shadow[byte_idx]. If byte_idx==13, go to IDLE (frame complete); otherwise byte_idx+1 and go to REQ with timer=0.
  - WAIT, rd_done with rd_err=1: abort.
- Timer: cleared on every REQ entry; increments each cycle in REQ and WAIT. If timer==TIMEOUT_CYC-1 with no rd_done that cycle, abort.
- rd_done arriving in the same cycle as timeout expiry takes priority; the byte is accepted.
- Abort: err_cnt+1 (saturating at all-ones); go to IDLE; rd_req=0; published outputs unchanged; shadow contents are don't-care.
- Frame complete, on the edge after the final rd_done:
  - Load all seven outputs simultaneously: word k = {shadow[2k], shadow[2k+1]} (high byte first). Order: ax, ay, az, temp, gx, gy, gz.
  - sample_valid=1 for exactly that one cycle.
  - Outputs never show a mix of old and new frames.
- Latency: tick in IDLE gives rd_req high in the next cycle. The final rd_done gives sample_valid in the next cycle, and busy=0 in that same cycle.
- Overrun: tick sampled while state != IDLE increments overrun_cnt (saturating), and the tick is dropped. A tick in the cycle that sample_valid is high is in IDLE and starts a new frame.
- init_done falling while in REQ or WAIT: go to IDLE next cycle, rd_req=0, no output update, no counter change. A late rd_done arriving in IDLE is ignored.
- rd_done arriving in REQ or IDLE is ignored.
- rd_ack arriving outside REQ is ignored.
- Counters saturate and never wrap. They are cleared only by rst.
- rst asserted mid-frame: immediate return to reset values, including the published outputs.

Test Plan:
- Nominal frame: init_done=1, tick; master acks after 2 cycles, done after 10, data bytes 0x01..0x0E. Required: rd_addr sequence 0x3B..0x48, ax=0x0102, temp=0x0708, gz=0x0D0E, one sample_valid pulse, busy low the same cycle.
- Overrun: 3 ticks during one frame, then a tick in the sample_valid cycle. Required: overrun_cnt=3, and a second frame starts immediately.
- Bus error on byte 5 (rd_err=1). Required: err_cnt=1, outputs keep the previous frame, no sample_valid; the next tick completes normally.
- Timeout with TIMEOUT_CYC=20: withhold rd_done. Required: abort after 20 cycles in REQ+WAIT, err_cnt=1. Second case: rd_done on cycle 20 exactly is accepted, no error.
- init_done=0 with tick: no rd_req. Drop init_done mid-frame: busy=0 next cycle, no counters change, late rd_done ignored.
- Saturation with CNT_W=2: 5 overruns give overrun_cnt=3. Async rst mid-WAIT: all outputs 0 immediately.
